// File: rtl/audio_dac_tx.sv
// Serial transmitter for a DAC121S101-class DAC: 12-bit samples in over valid/ready,
// 16-bit SPI frames out. Define DAC_SIGNED_EN to accept two's-complement samples.
module audio_dac_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic        basys_clk,
    input  logic        reset_n,
    input  logic [11:0] sample,
    input  logic [1:0]  pd,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        sync_n,
    output logic        sclk,
    output logic        din,
    output logic        busy,
    output logic        frame_done
);

    // state | meaning
    // IDLE  | waiting for a buffered sample; sync_n high, sclk high
    // SETUP | sync_n low, bit 15 on din, sclk high for one half period
    // SHIFT | 16 bit periods, sclk low then high; din advances on the rise
    // GAP   | sync_n high for two half periods; frame_done on the way out
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    localparam logic [7:0] HP_LOAD = 8'(CLK_DIV - 1);
`ifdef DAC_SIGNED_EN
    localparam logic [11:0] SIGN_FLIP = 12'h800;
`else
    localparam logic [11:0] SIGN_FLIP = 12'h000;
`endif

    state_t      state, state_nxt;
    logic        buf_full;
    logic [13:0] buf_word;
    logic [15:0] frame_word;
    logic [15:0] shift_reg, shift_nxt;
    logic [7:0]  hp_cnt, hp_nxt;
    logic [3:0]  bit_cnt, bit_nxt;
    logic        sync_nxt, sclk_nxt, din_nxt, busy_nxt, done_nxt;
    logic        accept, drain;

    assign sample_ready = !buf_full;
    assign accept       = sample_valid && !buf_full;
    assign frame_word   = {2'b00, buf_word};

    // accept and drain are mutually exclusive: one needs the buffer empty, the other full
    always_ff @(posedge basys_clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_full <= 1'b0;
            buf_word <= '0;
        end else if (accept) begin
            buf_full <= 1'b1;
            buf_word <= {pd, sample ^ SIGN_FLIP};
        end else if (drain) begin
            buf_full <= 1'b0;
        end
    end

    always_ff @(posedge basys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            hp_cnt     <= '0;
            bit_cnt    <= '0;
            sync_n     <= 1'b1;
            sclk       <= 1'b1;
            din        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift_reg  <= shift_nxt;
            hp_cnt     <= hp_nxt;
            bit_cnt    <= bit_nxt;
            sync_n     <= sync_nxt;
            sclk       <= sclk_nxt;
            din        <= din_nxt;
            busy       <= busy_nxt;
            frame_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        hp_nxt    = hp_cnt;
        bit_nxt   = bit_cnt;
        sync_nxt  = sync_n;
        sclk_nxt  = sclk;
        din_nxt   = din;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        drain     = 1'b0;
        unique case (state)
            IDLE: begin
                sync_nxt = 1'b1;
                sclk_nxt = 1'b1;
                din_nxt  = 1'b0;
                busy_nxt = 1'b0;
                if (buf_full) begin
                    drain     = 1'b1;
                    shift_nxt = frame_word;
                    din_nxt   = frame_word[15];
                    sync_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                    hp_nxt    = HP_LOAD;
                    bit_nxt   = 4'd15;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (hp_cnt != 8'd0) begin
                    hp_nxt = hp_cnt - 8'd1;
                end else begin
                    hp_nxt    = HP_LOAD;
                    sclk_nxt  = 1'b0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (hp_cnt != 8'd0) begin
                    hp_nxt = hp_cnt - 8'd1;
                end else begin
                    hp_nxt = HP_LOAD;
                    if (!sclk) begin
                        // rising edge: present the next bit; after the last bit din drops to 0
                        sclk_nxt  = 1'b1;
                        shift_nxt = {shift_reg[14:0], shift_reg[15]};
                        din_nxt   = (bit_cnt != 4'd0) ? shift_reg[14] : 1'b0;
                    end else if (bit_cnt == 4'd0) begin
                        sync_nxt  = 1'b1;
                        din_nxt   = 1'b0;
                        bit_nxt   = 4'd1;
                        state_nxt = GAP;
                    end else begin
                        bit_nxt  = bit_cnt - 4'd1;
                        sclk_nxt = 1'b0;
                    end
                end
            end
            GAP: begin
                if (hp_cnt != 8'd0) begin
                    hp_nxt = hp_cnt - 8'd1;
                end else if (bit_cnt != 4'd0) begin
                    bit_nxt = bit_cnt - 4'd1;
                    hp_nxt  = HP_LOAD;
                end else begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_audio_dac_tx.sv
// Self-checking bench for audio_dac_tx: frame-timeline reference model compared every cycle,
// plus directed latency/word checks and a CLK_DIV=2 instance.
module tb_audio_dac_tx;

    localparam int D  = 4;
    localparam int D2 = 2;

    logic        basys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] sample = '0;
    logic [1:0]  pd = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready, sync_n, sclk, din, busy, frame_done;

    logic [11:0] s2_sample = '0;
    logic        s2_valid = 1'b0;
    logic        s2_ready, s2_sync_n, s2_sclk, s2_din, s2_busy, s2_done;

    audio_dac_tx #(.CLK_DIV(D)) dut (
        .basys_clk(basys_clk), .reset_n(reset_n), .sample(sample), .pd(pd),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .sync_n(sync_n),
        .sclk(sclk), .din(din), .busy(busy), .frame_done(frame_done));

    audio_dac_tx #(.CLK_DIV(D2)) dut2 (
        .basys_clk(basys_clk), .reset_n(reset_n), .sample(s2_sample), .pd(2'b00),
        .sample_valid(s2_valid), .sample_ready(s2_ready), .sync_n(s2_sync_n),
        .sclk(s2_sclk), .din(s2_din), .busy(s2_busy), .frame_done(s2_done));

    always #5 basys_clk = ~basys_clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge basys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mkword(input logic [11:0] s, input logic [1:0] p);
`ifdef DAC_SIGNED_EN
        return {2'b00, p, s ^ 12'h800};
`else
        return {2'b00, p, s};
`endif
    endfunction

    // Reference model: a frame is a timeline of 35*D cycles from sync_n fall plus one idle cycle.
    bit          m_full = 1'b0;
    bit          m_act = 1'b0;
    int          m_k = 0;
    logic [15:0] m_word = '0;
    logic [15:0] m_bufw = '0;
    logic [15:0] exp_q[$];

    always @(posedge basys_clk or negedge reset_n) begin
        if (!reset_n) begin
            m_full = 1'b0;
            m_act  = 1'b0;
            m_k    = 0;
            exp_q.delete();
        end else begin
            bit was_full, acc, idle;
            was_full = m_full;
            acc      = sample_valid && !was_full;
            idle     = !m_act || (m_k == 35 * D);
            if (idle && was_full) begin
                m_act  = 1'b1;
                m_k    = 0;
                m_word = m_bufw;
                m_full = 1'b0;
            end else if (m_act) begin
                if (m_k == 35 * D) m_act = 1'b0;
                else m_k++;
            end
            if (acc) begin
                m_full = 1'b1;
                m_bufw = mkword(sample, pd);
                exp_q.push_back(m_bufw);
            end
        end
    end

    always @(negedge basys_clk) begin
        logic es, ec, ed, eb, ef;
        int j, p, r;
        es = 1'b1; ec = 1'b1; ed = 1'b0; eb = 1'b0; ef = 1'b0;
        if (m_act) begin
            if (m_k < D) begin
                es = 1'b0; eb = 1'b1; ed = m_word[15];
            end else if (m_k < 33 * D) begin
                j = m_k - D; p = j / (2 * D); r = j % (2 * D);
                es = 1'b0; eb = 1'b1;
                if (r < D) begin
                    ec = 1'b0; ed = m_word[15 - p];
                end else begin
                    ed = (p < 15) ? m_word[14 - p] : 1'b0;
                end
            end else if (m_k < 35 * D) begin
                eb = 1'b1;
            end else begin
                ef = 1'b1;
            end
        end
        chk("sync_n", {31'd0, sync_n}, {31'd0, es});
        chk("sclk", {31'd0, sclk}, {31'd0, ec});
        chk("din", {31'd0, din}, {31'd0, ed});
        chk("busy", {31'd0, busy}, {31'd0, eb});
        chk("frame_done", {31'd0, frame_done}, {31'd0, ef});
        chk("sample_ready", {31'd0, sample_ready}, {31'd0, !m_full});
    end

    // DAC-side decoder: shift din on sclk falls while selected; a frame counts only with 16 falls.
    logic [15:0] rx_sh = '0;
    logic [15:0] last_rx = '0;
    int rx_n = 0;
    int rx_cnt = 0;

    always @(negedge sclk) if (!sync_n) begin
        rx_sh = {rx_sh[14:0], din};
        rx_n++;
    end

    always @(posedge sync_n) begin
        if (rx_n == 16) begin
            last_rx = rx_sh;
            rx_cnt++;
            if (exp_q.size() > 0) begin
                chk("rx_word", {16'd0, rx_sh}, {16'd0, exp_q.pop_front()});
            end else begin
                n_vec++;
                n_err++;
                $display("FAIL rx_extra: got frame %0h, expected none", rx_sh);
            end
        end
        rx_n = 0;
    end

    int sf_q[$], sr_q[$], sf2_q[$], cf2_q[$];
    logic p_sync = 1'b1, p_sync2 = 1'b1, p_sclk2 = 1'b1;

    always @(negedge basys_clk) begin
        if (p_sync && !sync_n) sf_q.push_back(cyc);
        if (!p_sync && sync_n) sr_q.push_back(cyc);
        if (p_sync2 && !s2_sync_n) sf2_q.push_back(cyc);
        if (p_sclk2 && !s2_sclk && !s2_sync_n) cf2_q.push_back(cyc);
        p_sync  = sync_n;
        p_sync2 = s2_sync_n;
        p_sclk2 = s2_sclk;
    end

    task automatic send(input logic [11:0] s, input logic [1:0] p, input bit keep);
        int n;
        bit ok;
        n = 0; ok = 1'b0;
        sample = s; pd = p; sample_valid = 1'b1;
        while (!ok && n < 1000) begin
            @(negedge basys_clk);
            n++;
            if (sample_ready) begin
                @(posedge basys_clk);
                #1;
                ok = 1'b1;
            end
        end
        chk("send_accept", {31'd0, ok}, 32'd1);
        if (!keep) sample_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 1000) begin
            @(negedge basys_clk);
            n++;
        end
        chk(nm, {31'd0, frame_done}, 32'd1);
        @(posedge basys_clk);
        #1;
    endtask

    task automatic run_one(input logic [11:0] s, input logic [1:0] p, input string nm,
                           input logic [15:0] exp_word);
        send(s, p, 1'b0);
        wait_done({nm, "_done"});
        chk(nm, {16'd0, last_rx}, {16'd0, exp_word});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, tsf, n, falls, base;
        logic ps;

        repeat (3) @(posedge basys_clk);
        @(negedge basys_clk);
        chk("rst_sync_n", {31'd0, sync_n}, 32'd1);
        chk("rst_sclk", {31'd0, sclk}, 32'd1);
        chk("rst_din", {31'd0, din}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_ready", {31'd0, sample_ready}, 32'd1);
        reset_n = 1'b1;
        @(posedge basys_clk);
        #1;

        // single sample: latency to sync_n fall and to frame_done
        t0 = cyc;
        send(12'hA5C, 2'b00, 1'b0);
        n = 0;
        do begin @(negedge basys_clk); n++; end while (sync_n && n < 50);
        tsf = cyc;
        chk("sync_latency", tsf - t0, 32'd2);
        n = 0;
        while (frame_done !== 1'b1 && n < 400) begin @(negedge basys_clk); n++; end
        chk("done_latency", cyc - tsf, 32'd140);
`ifdef DAC_SIGNED_EN
        chk("word_a5c", {16'd0, last_rx}, 32'h025C);
`else
        chk("word_a5c", {16'd0, last_rx}, 32'h0A5C);
`endif
        @(posedge basys_clk);
        #1;

`ifdef DAC_SIGNED_EN
        run_one(12'hFFF, 2'b11, "word_pd3_fff", 16'h37FF);
        run_one(12'h800, 2'b00, "word_800", 16'h0000);
        run_one(12'h7FF, 2'b00, "word_7ff", 16'h0FFF);
`else
        run_one(12'hFFF, 2'b11, "word_pd3_fff", 16'h3FFF);
        run_one(12'h800, 2'b00, "word_800", 16'h0800);
        run_one(12'h7FF, 2'b00, "word_7ff", 16'h07FF);
`endif

        // valid held high across three samples: back-to-back frames
        repeat (5) begin @(posedge basys_clk); #1; end
        sf_q.delete();
        sr_q.delete();
        base = rx_cnt;
        send(12'h123, 2'b00, 1'b1);
        send(12'h456, 2'b01, 1'b1);
        send(12'h789, 2'b10, 1'b0);
        n = 0;
        while (rx_cnt < base + 3 && n < 1000) begin @(negedge basys_clk); n++; end
        chk("burst_frames", rx_cnt - base, 32'd3);
        chk("burst_falls", sf_q.size(), 32'd3);
        if (sf_q.size() >= 3 && sr_q.size() >= 2) begin
            chk("burst_span1", sf_q[1] - sf_q[0], 32'd141);
            chk("burst_span2", sf_q[2] - sf_q[1], 32'd141);
            chk("burst_gap1", sf_q[1] - sr_q[0], 32'd9);
            chk("burst_gap2", sf_q[2] - sr_q[1], 32'd9);
        end
        wait_done("burst_done");

        // reset at the 7th sclk fall with a second sample buffered
        send(12'h3C5, 2'b00, 1'b0);
        send(12'h111, 2'b00, 1'b0);
        falls = 0; n = 0; ps = sclk;
        while (falls < 7 && n < 400) begin
            @(negedge basys_clk);
            n++;
            if (ps && !sclk) falls++;
            ps = sclk;
        end
        chk("abort_falls", falls, 32'd7);
        base = rx_cnt;
        #2 reset_n = 1'b0;
        #1;
        chk("abort_sync_n", {31'd0, sync_n}, 32'd1);
        chk("abort_sclk", {31'd0, sclk}, 32'd1);
        chk("abort_din", {31'd0, din}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, sample_ready}, 32'd1);
        @(negedge basys_clk);
        reset_n = 1'b1;
        n = sf_q.size();
        repeat (200) @(negedge basys_clk);
        chk("no_restart", sf_q.size() - n, 32'd0);
        chk("abort_discard", rx_cnt - base, 32'd0);
        @(posedge basys_clk);
        #1;

        // randomized traffic
        for (int i = 0; i < 30; i++) begin
            int gap;
            gap = $urandom_range(0, 160);
            repeat (gap) begin @(posedge basys_clk); #1; end
            send(12'($urandom), 2'($urandom), 1'($urandom_range(0, 1)));
        end
        sample_valid = 1'b0;
        n = 0;
        while ((busy || !sample_ready || exp_q.size() != 0) && n < 2000) begin
            @(negedge basys_clk); n++;
        end
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        // CLK_DIV = 2 instance: sclk period and frame span
        @(posedge basys_clk);
        #1;
        s2_sample = 12'h5A5; s2_valid = 1'b1;
        n = 0;
        while (sf2_q.size() < 2 && n < 500) begin
            @(negedge basys_clk);
            n++;
            if (s2_ready) begin
                @(posedge basys_clk);
                #1;
                s2_sample = ~s2_sample;
            end
        end
        s2_valid = 1'b0;
        chk("d2_frames", sf2_q.size(), 32'd2);
        if (sf2_q.size() >= 2 && cf2_q.size() >= 2) begin
            chk("d2_sclk_period", cf2_q[1] - cf2_q[0], 32'd4);
            chk("d2_span", sf2_q[1] - sf2_q[0], 32'd71);
        end
        repeat (200) @(negedge basys_clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
